// File: rtl/mult_4b_arbiter.sv
// mult_4b_arbiter
// Round-robin arbiter that shares one combinational 4x4 multiplier (mult_4b)
// between two requesters. Exactly one operation is in flight at a time.
//
// Parameters:
//   MUL_LAT  cycles the operands are held on the multiplier before the
//            result is captured (legal 1..15)
//   CNT_W    width of the optional grant counters
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid/ready/x/y       request channel of port N (N = 0, 1)
//   respN_valid/ready/data     response channel of port N (4-bit product)
//   mul_x, mul_y, mul_out      operands to / result from the shared mult_4b
//   gnt_cnt0, gnt_cnt1         saturating grant counters (optional)
//   busy                       high whenever the FSM is not in IDLE
//
// Optional feature: define MULT_4B_ARBITER_STATS_EN to add the grant
// counters gnt_cnt0/gnt_cnt1.
//
// Every output comes straight from a flop. The handshake flags are loaded
// from the next-state decode, so they line up with the state they belong to.
module mult_4b_arbiter #(
  parameter int MUL_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_x,
  input  logic [3:0]       req0_y,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [3:0]       resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_x,
  input  logic [3:0]       req1_y,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [3:0]       resp1_data,
  output logic [3:0]       mul_x,
  output logic [3:0]       mul_y,
  input  logic [3:0]       mul_out,
`ifdef MULT_4B_ARBITER_STATS_EN
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter value on the last EXEC cycle.
  localparam logic [3:0] LAST_CNT = 4'(MUL_LAT - 1);

  state_t     state_r, state_s;
  logic       gnt_r, gnt_s;
  logic       last_grant_r;
  logic [3:0] op_x_r, op_y_r;
  logic [3:0] exec_cnt_r;
  logic [3:0] result0_r, result1_r;
  logic       req0_ready_r, req1_ready_r;
  logic       resp0_valid_r, resp1_valid_r;
  logic       busy_r;
  logic       resp_ready_s;
  logic       exec_done_s;

  assign resp_ready_s = gnt_r ? resp1_ready : resp0_ready;
  assign exec_done_s  = (state_r == EXEC) && (exec_cnt_r == LAST_CNT);

  // Next-state and winner selection.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // Contention: the port that did not win last time goes next.
          state_s = GRANT;
          gnt_s   = ~last_grant_r;
        end else if (req0_valid) begin
          state_s = GRANT;
          gnt_s   = 1'b0;
        end else if (req1_valid) begin
          state_s = GRANT;
          gnt_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s = EXEC;
      end
      EXEC: begin
        if (exec_done_s) begin
          state_s = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (resp_ready_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 1'b0;
      end
    endcase
  end

  // State, operand, counter and result registers plus registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      gnt_r         <= 1'b0;
      last_grant_r  <= 1'b1;
      op_x_r        <= 4'd0;
      op_y_r        <= 4'd0;
      exec_cnt_r    <= 4'd0;
      result0_r     <= 4'd0;
      result1_r     <= 4'd0;
      req0_ready_r  <= 1'b0;
      req1_ready_r  <= 1'b0;
      resp0_valid_r <= 1'b0;
      resp1_valid_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      gnt_r         <= gnt_s;
      req0_ready_r  <= (state_s == GRANT) && !gnt_s;
      req1_ready_r  <= (state_s == GRANT) &&  gnt_s;
      resp0_valid_r <= (state_s == RESP)  && !gnt_s;
      resp1_valid_r <= (state_s == RESP)  &&  gnt_s;
      busy_r        <= (state_s != IDLE);
      if (state_r == GRANT) begin
        op_x_r       <= gnt_r ? req1_x : req0_x;
        op_y_r       <= gnt_r ? req1_y : req0_y;
        last_grant_r <= gnt_r;
        exec_cnt_r   <= 4'd0;
      end else if (state_r == EXEC) begin
        exec_cnt_r <= exec_cnt_r + 4'd1;
        // Each port keeps its own result so its data holds after transfer.
        if (exec_done_s && gnt_r) begin
          result1_r <= mul_out;
        end else if (exec_done_s) begin
          result0_r <= mul_out;
        end
      end
    end
  end

  assign req0_ready  = req0_ready_r;
  assign req1_ready  = req1_ready_r;
  assign resp0_valid = resp0_valid_r;
  assign resp1_valid = resp1_valid_r;
  assign resp0_data  = result0_r;
  assign resp1_data  = result1_r;
  assign mul_x       = op_x_r;
  assign mul_y       = op_y_r;
  assign busy        = busy_r;

`ifdef MULT_4B_ARBITER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] gnt_cnt0_r, gnt_cnt1_r;

  // Saturating per-port counters of accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_r <= '0;
      gnt_cnt1_r <= '0;
    end else begin
      if (req0_ready_r && req0_valid && (gnt_cnt0_r != CNT_MAX)) begin
        gnt_cnt0_r <= gnt_cnt0_r + CNT_W'(1);
      end
      if (req1_ready_r && req1_valid && (gnt_cnt1_r != CNT_MAX)) begin
        gnt_cnt1_r <= gnt_cnt1_r + CNT_W'(1);
      end
    end
  end

  assign gnt_cnt0 = gnt_cnt0_r;
  assign gnt_cnt1 = gnt_cnt1_r;
`endif

endmodule

// File: tb/tb_mult_4b_arbiter.sv
// Testbench for mult_4b_arbiter. Instance a uses MUL_LAT=1, instance b uses
// MUL_LAT=3 (and CNT_W=2 for the saturation case). Expected products are
// queued per port when a request is driven and popped when the response
// handshake is seen.
module tb_mult_4b_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a signals
  logic       a_r0v = 1'b0, a_r1v = 1'b0, a_p0r = 1'b1, a_p1r = 1'b1;
  logic [3:0] a_r0x = 4'd0, a_r0y = 4'd0, a_r1x = 4'd0, a_r1y = 4'd0;
  logic       a_r0rdy, a_r1rdy, a_p0v, a_p1v, a_busy;
  logic [3:0] a_p0d, a_p1d, a_mx, a_my, a_mo;
  logic [7:0] a_prod;
  // instance b signals
  logic       b_r0v = 1'b0, b_r1v = 1'b0, b_p0r = 1'b1, b_p1r = 1'b1;
  logic [3:0] b_r0x = 4'd0, b_r0y = 4'd0, b_r1x = 4'd0, b_r1y = 4'd0;
  logic       b_r0rdy, b_r1rdy, b_p0v, b_p1v, b_busy;
  logic [3:0] b_p0d, b_p1d, b_mx, b_my, b_mo;
  logic [7:0] b_prod;
`ifdef MULT_4B_ARBITER_STATS_EN
  logic [7:0] a_c0, a_c1;
  logic [1:0] b_c0, b_c1;
`endif

  // Shared combinational multipliers (mult_4b behaviour: truncated product).
  assign a_prod = {4'd0, a_mx} * {4'd0, a_my};
  assign a_mo   = a_prod[3:0];
  assign b_prod = {4'd0, b_mx} * {4'd0, b_my};
  assign b_mo   = b_prod[3:0];

  mult_4b_arbiter #(.MUL_LAT(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_r0v), .req0_ready(a_r0rdy), .req0_x(a_r0x), .req0_y(a_r0y),
    .resp0_valid(a_p0v), .resp0_ready(a_p0r), .resp0_data(a_p0d),
    .req1_valid(a_r1v), .req1_ready(a_r1rdy), .req1_x(a_r1x), .req1_y(a_r1y),
    .resp1_valid(a_p1v), .resp1_ready(a_p1r), .resp1_data(a_p1d),
    .mul_x(a_mx), .mul_y(a_my), .mul_out(a_mo),
`ifdef MULT_4B_ARBITER_STATS_EN
    .gnt_cnt0(a_c0), .gnt_cnt1(a_c1),
`endif
    .busy(a_busy)
  );

  mult_4b_arbiter #(.MUL_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_x(b_r0x), .req0_y(b_r0y),
    .resp0_valid(b_p0v), .resp0_ready(b_p0r), .resp0_data(b_p0d),
    .req1_valid(b_r1v), .req1_ready(b_r1rdy), .req1_x(b_r1x), .req1_y(b_r1y),
    .resp1_valid(b_p1v), .resp1_ready(b_p1r), .resp1_data(b_p1d),
    .mul_x(b_mx), .mul_y(b_my), .mul_out(b_mo),
`ifdef MULT_4B_ARBITER_STATS_EN
    .gnt_cnt0(b_c0), .gnt_cnt1(b_c1),
`endif
    .busy(b_busy)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp0_q[$];
  logic [3:0] exp1_q[$];
  logic       grant_log[$];
  logic       a_r0v_q = 1'b0, a_r0rdy_q = 1'b0, a_r1v_q = 1'b0, a_r1rdy_q = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] prod4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] p;
    p = {4'd0, x} * {4'd0, y};
    return p[3:0];
  endfunction

  // Response scoreboard, grant log and requester hold rule for instance a.
  always @(negedge clk) begin
    if (a_p0v && a_p0r) begin
      if (exp0_q.size() == 0) check_val("resp0_unexpected", 32'd1, 32'd0);
      else check_val("resp0_data", {28'd0, a_p0d}, {28'd0, exp0_q.pop_front()});
    end
    if (a_p1v && a_p1r) begin
      if (exp1_q.size() == 0) check_val("resp1_unexpected", 32'd1, 32'd0);
      else check_val("resp1_data", {28'd0, a_p1d}, {28'd0, exp1_q.pop_front()});
    end
    if (a_p0v || a_p1v) check_val("resp_onehot", {31'd0, a_p0v & a_p1v}, 32'd0);
    if (a_r0rdy) grant_log.push_back(1'b0);
    if (a_r1rdy) grant_log.push_back(1'b1);
    if (a_r0v_q && !a_r0rdy_q && !a_r0v) check_val("req0_hold", {31'd0, a_r0v}, 32'd1);
    if (a_r1v_q && !a_r1rdy_q && !a_r1v) check_val("req1_hold", {31'd0, a_r1v}, 32'd1);
    a_r0v_q   <= a_r0v;
    a_r0rdy_q <= a_r0rdy;
    a_r1v_q   <= a_r1v;
    a_r1rdy_q <= a_r1rdy;
  end

  task automatic issue0(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    a_r0x = x; a_r0y = y; a_r0v = 1'b1;
    exp0_q.push_back(prod4(x, y));
    while (n < 60) begin
      @(negedge clk);
      if (a_r0rdy) break;
      n++;
    end
    if (n >= 60) check_val("req0_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_r0v = 1'b0;
  endtask

  task automatic issue1(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    a_r1x = x; a_r1y = y; a_r1v = 1'b1;
    exp1_q.push_back(prod4(x, y));
    while (n < 60) begin
      @(negedge clk);
      if (a_r1rdy) break;
      n++;
    end
    if (n >= 60) check_val("req1_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_r1v = 1'b0;
  endtask

  task automatic wait_a_idle();
    int n = 0;
    @(negedge clk);
    while ((a_busy || exp0_q.size() != 0 || exp1_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef MULT_4B_ARBITER_STATS_EN
  task automatic b_op(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    b_r0x = x; b_r0y = y; b_r0v = 1'b1;
    while (n < 60) begin
      @(negedge clk);
      if (b_r0rdy) break;
      n++;
    end
    if (n >= 60) check_val("b_req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    b_r0v = 1'b0;
    n = 0;
    @(negedge clk);
    while (b_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check_val("b_idle_timeout", 32'd0, 32'd1);
  endtask
`endif

  initial begin
    // Reset state, during and after reset
    #12;
    check_val("rst_outs_a", {23'd0, a_r0rdy, a_r1rdy, a_p0v, a_p1v, a_busy, a_mx}, 32'd0);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    check_val("idle_outs_a", {13'd0, a_r0rdy, a_r1rdy, a_p0v, a_p1v, a_busy, a_mx, a_my, a_p0d, a_p1d}, 32'd0);
    check_val("idle_outs_b", {13'd0, b_r0rdy, b_r1rdy, b_p0v, b_p1v, b_busy, b_mx, b_my, b_p0d, b_p1d}, 32'd0);

    // Port 0 alone, MUL_LAT=1: ready at cycle 1, response at cycle 3
    @(posedge clk); #1;
    a_r0x = 4'b1000; a_r0y = 4'b1001; a_r0v = 1'b1;
    exp0_q.push_back(prod4(4'b1000, 4'b1001));
    @(posedge clk); #1;
    check_val("p0_c1", {29'd0, a_r0rdy, a_r1rdy, a_busy}, 32'b101);
    @(posedge clk); #1;
    a_r0v = 1'b0;
    check_val("p0_c2", {30'd0, a_r0rdy, a_p0v}, 32'd0);
    check_val("p0_mulx", {28'd0, a_mx}, 32'd8);
    @(posedge clk); #1;
    check_val("p0_c3", {26'd0, a_p0v, a_p1v, a_p0d}, {26'd0, 2'b10, 4'b1000});
    @(posedge clk); #1;
    check_val("p0_c4", {30'd0, a_p0v, a_busy}, 32'd0);
    check_val("p0_hold", {28'd0, a_p0d}, 32'd8);
    wait_a_idle();

    // Both ports continuously valid: strict alternation starting with port 0
    do_reset();
    grant_log.delete();
    fork
      begin issue0(4'b1101, 4'b0110); issue0(4'd15, 4'd15); issue0(4'd2, 4'd3); end
      begin issue1(4'b0011, 4'b0011); issue1(4'd4, 4'd5); issue1(4'd7, 4'd7); end
    join
    wait_a_idle();
    check_val("alt_count", grant_log.size(), 32'd6);
    for (int i = 0; i < grant_log.size(); i++)
      check_val("alt_order", {31'd0, grant_log[i]}, i % 2);

    // Backpressure on port 0 while port 1 waits
    a_p0r = 1'b0;
    issue0(4'd5, 4'd3);
    a_r1x = 4'd2; a_r1y = 4'd7; a_r1v = 1'b1;
    exp1_q.push_back(prod4(4'd2, 4'd7));
    begin
      int n = 0;
      @(negedge clk);
      while (!a_p0v && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check_val("bp_valid_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      check_val("bp_hold", {25'd0, a_p0v, a_p0d, a_r1rdy, a_p1v}, {25'd0, 1'b1, 4'hF, 1'b0, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_p0r = 1'b1;
    @(posedge clk); #1;
    check_val("bp_idle", {29'd0, a_p0v, a_r1rdy, a_busy}, 32'd0);
    @(posedge clk); #1;
    check_val("bp_grant1", {30'd0, a_r1rdy, a_busy}, 32'b11);
    @(posedge clk); #1;
    a_r1v = 1'b0;
    wait_a_idle();

    // MUL_LAT=3: three EXEC cycles, response at cycle 5
    @(posedge clk); #1;
    b_r0x = 4'd7; b_r0y = 4'd6; b_r0v = 1'b1;
    @(posedge clk); #1;
    check_val("lat3_c1", {30'd0, b_r0rdy, b_busy}, 32'b11);
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      b_r0v = 1'b0;
      check_val("lat3_exec", {30'd0, b_p0v, b_busy}, 32'b01);
    end
    @(posedge clk); #1;
    check_val("lat3_c5", {27'd0, b_p0v, b_p0d}, {27'd0, 1'b1, prod4(4'd7, 4'd6)});
    @(posedge clk); #1;
    check_val("lat3_c6", {31'd0, b_p0v}, 32'd0);

    // Reset pulsed during EXEC: outputs clear at once, op is dropped
    @(posedge clk); #1;
    a_r0x = 4'd7; a_r0y = 4'd3; a_r0v = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_r0v = 1'b0;
    check_val("rst_exec_pre", {27'd0, a_busy, a_mx}, {27'd0, 1'b1, 4'd7});
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_exec_outs", {13'd0, a_r0rdy, a_r1rdy, a_p0v, a_p1v, a_busy, a_mx, a_my, a_p0d, a_p1d}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_no_resp", {30'd0, a_p0v, a_busy}, 32'd0);
    issue0(4'd9, 4'd9);
    wait_a_idle();
`ifdef MULT_4B_ARBITER_STATS_EN
    check_val("gnt_cnt0", {24'd0, a_c0}, 32'd1);
    check_val("gnt_cnt1", {24'd0, a_c1}, 32'd0);
    for (int i = 0; i < 5; i++) b_op(4'd3, 4'd2);
    check_val("gnt_sat", {30'd0, b_c0}, 32'd3);
`endif
    check_val("queues_empty", exp0_q.size() + exp1_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mult_4b_arbiter.md
Name: mult_4b_arbiter

Overview:
- Shares one combinational mult_4b instance between two requesters (port 0, port 1).
- Each port uses a valid/ready request channel (x, y operands) and a valid/ready response channel (4-bit product, truncated as mult_4b produces).
- Arbitration is round-robin; one operation is in flight at a time. Sits between issuing units and the shared multiplier.

Parameters:
- MUL_LAT, 1, EXEC cycles operands are held on the multiplier before the result is captured (legal 1..15).
- CNT_W, 8, width of the optional grant counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  port 0 request valid.
- req0_ready  output  1  port 0 request accepted.
- req0_x  input  4  port 0 operand x.
- req0_y  input  4  port 0 operand y.
- resp0_valid  output  1  port 0 result valid.
- resp0_ready  input  1  port 0 consumer ready.
- resp0_data  output  4  port 0 result.
- req1_valid, req1_ready, req1_x, req1_y, resp1_valid, resp1_ready, resp1_data: same as port 0, for port 1.
- mul_x  output  4  operand x to mult_4b.
- mul_y  output  4  operand y to mult_4b.
- mul_out  input  4  mult_4b result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, GRANT, EXEC, RESP. All outputs are registered or decoded from state.
- Reset (async, rst_n low):
  - state=IDLE, last_grant=1 (so port 0 wins first), op regs=0, result=0, exec counter=0.
  - All ready/valid outputs 0, mul_x=mul_y=0, resp data=0, busy=0.
- IDLE:
  - If any req valid, pick a winner: if only one is valid, that one; if both, the port other than last_grant.
  - Register the winner in gnt, go to GRANT. Otherwise stay.
- GRANT:
  - reqG_ready=1 (G = gnt) for exactly one cycle.
  - Requester rule: valid must not drop before ready. Bench asserts this; the arbiter does not check it.
  - On the clock edge, capture reqG_x/reqG_y into the op regs, set last_grant=gnt, clear the counter, go to EXEC.
- EXEC:
  - mul_x/mul_y are driven from the op regs at all times.
  - The counter increments each cycle.
  - When counter==MUL_LAT-1: capture mul_out into result, go to RESP.
- RESP:
  - respG_valid=1 and respG_data=result, held stable until respG_ready=1 at a clock edge; then go to IDLE.
  - respG_data holds its last value after the transfer.
  - The other port's resp_valid is 0.
- Latency: req valid in IDLE at cycle 0 → ready at cycle 1 → resp_valid at cycle 2+MUL_LAT, assuming resp_ready is already high.
  - Peak throughput: one op per 3+MUL_LAT cycles.
- Simultaneous events:
  - A request arriving during GRANT/EXEC/RESP waits; it is granted next from IDLE per round-robin.
  - Both valid continuously → strict alternation 0,1,0,1.
  - resp_ready high before resp_valid is legal; transfer happens on the first RESP cycle.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and all outputs return to reset values immediately (async).
- Arithmetic: no widening; result is mul_out exactly as the multiplier produces it (4 bits).

Optional Feature:
- Macro: MULT_4B_ARBITER_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 [CNT_W-1:0].
  - Each increments on its port's GRANT handshake and saturates at all-ones.
  - Both reset to 0.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, busy=0, mul_x=mul_y=0.
- Port 0 only, x=4'b1000, y=4'b1001, MUL_LAT=1, resp0_ready=1 → req0_ready at cycle 1; resp0_valid at cycle 3 with data=4'b1000 (low 4 bits of 72); resp1_valid stays 0.
- Both ports valid from cycle 0: port 0 x=4'b1101, y=4'b0110; port 1 x=4'b0011, y=4'b0011; both hold valid until their ready → grants alternate, port 0 first. resp0_data=4'b1110 (low 4 bits of 78); resp1_data=4'b1001.
- Backpressure: resp0_ready=0 for 6 cycles → resp0_valid and data hold stable; a pending req1 is not granted until the resp0 transfer completes, then IDLE → GRANT port 1.
- MUL_LAT=3 → exactly 3 EXEC cycles; resp_valid at cycle 5 after request.
- rst_n pulsed low during EXEC → outputs 0 immediately; after release, a new port 0 request completes normally. With STATS_EN defined, gnt_cnt0=1 after that request; CNT_W=2 saturates at 3 after 5 grants.
